// File: rtl/toggle_activity_monitor_if.sv
// Stream/control bundle for toggle_activity_monitor.
// The master side is the monitor; the slave side is the consumer and stimulus source.
interface toggle_activity_monitor_if #(
  parameter int unsigned NUM_SIG = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WIN_W   = 16
);
  localparam int unsigned IDX_W = $clog2(NUM_SIG) + 1;

  logic               en;
  logic [NUM_SIG-1:0] sig;
  logic [WIN_W-1:0]   win_len;
  logic               out_ready;
  logic               out_valid;
  logic [IDX_W-1:0]   out_idx;
  logic [CNT_W-1:0]   out_count;
  logic               out_last;
  logic               out_sat;
  logic               overrun;

  modport master (
    input  en, sig, win_len, out_ready,
    output out_valid, out_idx, out_count, out_last, out_sat, overrun
  );

  modport slave (
    output en, sig, win_len, out_ready,
    input  out_valid, out_idx, out_count, out_last, out_sat, overrun
  );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Per-net toggle counter over a programmable enabled-cycle window, with a double-buffered
// snapshot streamed out beat by beat. Define ACT_TOTAL_EN to append a summed-total beat.
module toggle_activity_monitor #(
  parameter int unsigned NUM_SIG = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WIN_W   = 16
) (
  input logic                      clk,
  input logic                      rst,
  toggle_activity_monitor_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_SIG) + 1;
`ifdef ACT_TOTAL_EN
  localparam int unsigned LAST_IDX = NUM_SIG;
  localparam int unsigned SUM_W    = CNT_W + IDX_W;
`else
  localparam int unsigned LAST_IDX = NUM_SIG - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  logic [NUM_SIG-1:0] prev;
  logic               prev_valid;
  logic [NUM_SIG-1:0] tog;
  logic [CNT_W-1:0]   cnt      [NUM_SIG];
  logic [CNT_W-1:0]   cnt_nxt  [NUM_SIG];
  logic [NUM_SIG-1:0] cnt_sat_nxt;
  logic [CNT_W-1:0]   snap     [NUM_SIG];
  logic [NUM_SIG-1:0] snap_sat;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   lat_len;
  logic [WIN_W-1:0]   eff_len;
  logic [WIN_W-1:0]   cur_len;
  logic               win_close;
  logic [IDX_W-1:0]   nxt_idx;
  logic [CNT_W-1:0]   nxt_count;
  logic               nxt_sat;

  assign tog = prev_valid ? (bus.sig ^ prev) : '0;

  // Saturating increment; the closing-cycle toggle is folded in before the snapshot.
  always_comb begin
    cnt_sat_nxt = '0;
    for (int i = 0; i < int'(NUM_SIG); i++) begin
      cnt_nxt[i] = cnt[i];
      if (cnt[i] != CNT_MAX) cnt_nxt[i] = cnt[i] + CNT_W'(tog[i]);
      cnt_sat_nxt[i] = (cnt_nxt[i] == CNT_MAX);
    end
  end

  assign eff_len   = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  assign cur_len   = (win_cnt == '0) ? eff_len : lat_len;
  assign win_close = bus.en && ((win_cnt + WIN_W'(1)) == cur_len);
  assign nxt_idx   = bus.out_idx + IDX_W'(1);

`ifdef ACT_TOTAL_EN
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] tot_count;
  logic             tot_sat;

  always_comb begin
    sum     = '0;
    tot_sat = |snap_sat;
    for (int i = 0; i < int'(NUM_SIG); i++) sum = sum + SUM_W'(snap[i]);
    tot_count = sum[CNT_W-1:0];
    if (sum >= SUM_W'(CNT_MAX)) begin
      tot_count = CNT_MAX;
      tot_sat   = 1'b1;
    end
  end
`endif

  // Payload of the beat that follows the current one.
  always_comb begin
    nxt_count = '0;
    nxt_sat   = 1'b0;
    for (int i = 0; i < int'(NUM_SIG); i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        nxt_count = snap[i];
        nxt_sat   = snap_sat[i];
      end
    end
`ifdef ACT_TOTAL_EN
    if (nxt_idx == IDX_W'(NUM_SIG)) begin
      nxt_count = tot_count;
      nxt_sat   = tot_sat;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      prev_valid <= 1'b0;
      win_cnt    <= '0;
      lat_len    <= '0;
      snap_sat   <= '0;
      for (int i = 0; i < int'(NUM_SIG); i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_count <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sat   <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.en) begin
        prev       <= bus.sig;
        prev_valid <= 1'b1;
        if (win_close) begin
          win_cnt <= '0;
          for (int i = 0; i < int'(NUM_SIG); i++) cnt[i] <= '0;
          if (state == IDLE) begin
            for (int i = 0; i < int'(NUM_SIG); i++) snap[i] <= cnt_nxt[i];
            snap_sat      <= cnt_sat_nxt;
            state         <= STREAM;
            bus.out_valid <= 1'b1;
            bus.out_idx   <= '0;
            bus.out_count <= cnt_nxt[0];
            bus.out_sat   <= cnt_sat_nxt[0];
            bus.out_last  <= (LAST_IDX == 0);
          end else begin
            bus.overrun <= 1'b1;
          end
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          for (int i = 0; i < int'(NUM_SIG); i++) cnt[i] <= cnt_nxt[i];
          if (win_cnt == '0) lat_len <= eff_len;
        end
      end else begin
        prev_valid <= 1'b0;
      end

      // Beat acceptance; mutually exclusive with capture since capture needs IDLE.
      if (state == STREAM && bus.out_ready) begin
        if (bus.out_last) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end else begin
          bus.out_idx   <= nxt_idx;
          bus.out_count <= nxt_count;
          bus.out_sat   <= nxt_sat;
          bus.out_last  <= (nxt_idx == IDX_W'(LAST_IDX));
        end
      end
    end
  end
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus; checks follow hand-computed cycle-by-cycle expectations.
module tb_toggle_activity_monitor;
`ifdef ACT_TOTAL_EN
  localparam int NBEATS = 9;
`else
  localparam int NBEATS = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  sig;
  logic [15:0] win_len;
  logic        ready;
  int          compared = 0;
  int          mismatched = 0;

  toggle_activity_monitor_if #(.NUM_SIG(8), .CNT_W(16), .WIN_W(16)) a_if ();
  toggle_activity_monitor_if #(.NUM_SIG(8), .CNT_W(4),  .WIN_W(16)) b_if ();

  assign a_if.en = en;  assign a_if.sig = sig;  assign a_if.win_len = win_len;  assign a_if.out_ready = ready;
  assign b_if.en = en;  assign b_if.sig = sig;  assign b_if.win_len = win_len;  assign b_if.out_ready = ready;

  toggle_activity_monitor #(.NUM_SIG(8), .CNT_W(16), .WIN_W(16)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  toggle_activity_monitor #(.NUM_SIG(8), .CNT_W(4),  .WIN_W(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sig = '0; win_len = '0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp6 [9] = '{1, 2, 3, 0, 0, 0, 0, 0, 6};

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid",   32'(a_if.out_valid), 0);
    chk("rst_idx",     32'(a_if.out_idx),   0);
    chk("rst_count",   32'(a_if.out_count), 0);
    chk("rst_last",    32'(a_if.out_last),  0);
    chk("rst_sat",     32'(a_if.out_sat),   0);
    chk("rst_overrun", 32'(a_if.overrun),   0);
    chk("rst_b_valid", 32'(b_if.out_valid), 0);

    // Test 1: win_len=4, bit0 toggles each cycle
    win_len = 16'd4; en = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      sig[0] = ~sig[0];
      if (k >= 4 && k <= 11) begin
        chk($sformatf("t1_valid_%0d", k), 32'(a_if.out_valid), 1);
        chk($sformatf("t1_idx_%0d", k),   32'(a_if.out_idx),   32'(k - 4));
        chk($sformatf("t1_count_%0d", k), 32'(a_if.out_count), (k == 4) ? 3 : 0);
        chk($sformatf("t1_last_%0d", k),  32'(a_if.out_last),  32'(k == 11 && NBEATS == 8));
      end
      if (k == 12 && NBEATS == 8) chk("t1_valid_drop", 32'(a_if.out_valid), 0);
    end
    if (NBEATS == 8) begin
      chk("t1_w4_valid", 32'(a_if.out_valid), 1);
      chk("t1_w4_idx",   32'(a_if.out_idx),   0);
      chk("t1_w4_count", 32'(a_if.out_count), 4);
    end
    chk("t1_overrun", 32'(a_if.overrun), 1);

    // Test 2: win_len=0 closes every enabled cycle
    do_reset();
    win_len = 16'd0; en = 1'b1; ready = 1'b1;
    tick();
    sig[3] = ~sig[3];
    chk("t2_valid_1",   32'(a_if.out_valid), 1);
    chk("t2_overrun_1", 32'(a_if.overrun),   0);
    tick();
    sig[3] = ~sig[3];
    chk("t2_overrun_2", 32'(a_if.overrun), 1);
    chk("t2_idx_2",     32'(a_if.out_idx), 1);

    // Test 3: 4-bit counters saturate at 15
    do_reset();
    win_len = 16'd40; en = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      tick();
      sig[1] = ~sig[1];
      if (k == 39) chk("t3_valid_early", 32'(b_if.out_valid), 0);
      if (k == 40) begin
        chk("t3_b0_count", 32'(b_if.out_count), 0);
        chk("t3_b0_sat",   32'(b_if.out_sat),   0);
      end
      if (k == 41) begin
        chk("t3_b1_idx",   32'(b_if.out_idx),   1);
        chk("t3_b1_count", 32'(b_if.out_count), 15);
        chk("t3_b1_sat",   32'(b_if.out_sat),   1);
      end
    end

    // Test 4: backpressure holds the beat
    do_reset();
    win_len = 16'd4; en = 1'b1; ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      sig[0] = ~sig[0];
    end
    en = 1'b0;
    chk("t4_count0", 32'(a_if.out_count), 3);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t4_hold_valid_%0d", k), 32'(a_if.out_valid), 1);
      chk($sformatf("t4_hold_idx_%0d", k),   32'(a_if.out_idx),   0);
      chk($sformatf("t4_hold_count_%0d", k), 32'(a_if.out_count), 3);
    end
    ready = 1'b1;
    for (int b = 1; b < NBEATS; b++) begin
      tick();
      chk($sformatf("t4_idx_%0d", b),   32'(a_if.out_idx),   32'(b));
      chk($sformatf("t4_count_%0d", b), 32'(a_if.out_count), (b == 8) ? 3 : 0);
      chk($sformatf("t4_last_%0d", b),  32'(a_if.out_last),  32'(b == NBEATS - 1));
    end
    tick();
    chk("t4_valid_end", 32'(a_if.out_valid), 0);

    // Test 5: reset mid-stream
    do_reset();
    win_len = 16'd4; en = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      sig[0] = ~sig[0];
    end
    chk("t5_idx3", 32'(a_if.out_idx), 3);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(a_if.out_valid), 0);
    chk("t5_rst_idx",   32'(a_if.out_idx),   0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      sig[0] = ~sig[0];
      if (k == 3) chk("t5_valid_pre", 32'(a_if.out_valid), 0);
    end
    chk("t5_valid", 32'(a_if.out_valid), 1);
    chk("t5_count", 32'(a_if.out_count), 3);

    // Test 6: counts {1,2,3,0,...} (plus total beat when enabled)
    do_reset();
    win_len = 16'd4; en = 1'b1; ready = 1'b1;
    tick(); sig = 8'h07;
    tick(); sig = 8'h01;
    tick(); sig = 8'h05;
    tick(); en = 1'b0;
    for (int b = 0; b < NBEATS; b++) begin
      if (b > 0) tick();
      chk($sformatf("t6_idx_%0d", b),   32'(a_if.out_idx),   32'(b));
      chk($sformatf("t6_count_%0d", b), 32'(a_if.out_count), 32'(exp6[b]));
      chk($sformatf("t6_sat_%0d", b),   32'(a_if.out_sat),   0);
      chk($sformatf("t6_last_%0d", b),  32'(a_if.out_last),  32'(b == NBEATS - 1));
    end
    tick();
    chk("t6_valid_end", 32'(a_if.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
